// File: rtl/opb_register_simulink2ppc_latched_if.sv
// OPB master/slave signal bundle for the simulink2ppc read-back register.
// Bit 0 is the MSB, following OPB numbering.
interface opb_register_simulink2ppc_latched_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [0:AW-1]     OPB_ABus;
    logic [0:DW/8-1]   OPB_BE;
    logic [0:DW-1]     OPB_DBus;
    logic              OPB_RNW;
    logic              OPB_select;
    logic              OPB_seqAddr;
    logic [0:DW-1]     Sl_DBus;
    logic              Sl_xferAck;
    logic              Sl_errAck;
    logic              Sl_retry;
    logic              Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_simulink2ppc_latched.sv
// Latches a fabric word with new/overflow status for PPC read-back; optional capture timestamp under OPB_SIM2PPC_TIMESTAMP_EN.
// Latency: hit sampled at edge N, Sl_xferAck high for the cycle after edge N+1; user_new is a direct register output.
// Backpressure: none on the fabric side; one ack per OPB_select, slave waits in HOLD until select drops.
module opb_register_simulink2ppc_latched #(
    parameter logic [31:0] C_BASEADDR   = 32'h0110A100,
    parameter logic [31:0] C_HIGHADDR   = 32'h0110A1FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex6"
) (
    input  logic                                       OPB_Clk,
    input  logic                                       OPB_Rst_n,
    opb_register_simulink2ppc_latched_if.slave         opb,
    input  logic [31:0]                                user_data_in,
    input  logic                                       user_valid,
    output logic                                       user_new
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam bit FAMILY_V6 = (C_FAMILY == "virtex6");

    logic [1:0]              state;
    logic [C_OPB_AWIDTH-1:0] addr;
    logic                    hit;
    logic [1:0]              idx_q;
    logic                    rnw_q;
    logic                    be3_q;
    logic [1:0]              wctl_q;
    logic [C_OPB_DWIDTH-1:0] rd_snap;
    logic [C_OPB_DWIDTH-1:0] rd_word;
    logic [C_OPB_DWIDTH-1:0] sl_dbus;
    logic                    xfer_ack;

    logic [31:0] data_reg;
    logic        new_flag;
    logic [15:0] ovf_cnt;
    logic        freeze;
    logic [31:0] tstamp;

    logic acc, ctrl_wr, ovf_clr, data_rd, capture, ovf_inc;
    logic unused_ok;

    assign addr = opb.OPB_ABus;
    assign hit  = opb.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

    always_comb begin
        rd_word = '0;
        case (opb.OPB_ABus[28:29])
            2'd0:    rd_word = data_reg;
            2'd1:    rd_word = {8'h00, ovf_cnt, 7'h00, new_flag};
            2'd2:    rd_word = {30'h0, freeze, 1'b0};
            default: rd_word = tstamp;
        endcase
    end

    // Register side effects of a transfer land on the edge that leaves ACK.
    assign acc     = (state == ST_ACK);
    assign ctrl_wr = acc && !rnw_q && (idx_q == 2'd2) && be3_q;
    assign ovf_clr = ctrl_wr && wctl_q[0];
    assign data_rd = acc && rnw_q && (idx_q == 2'd0);
    assign capture = user_valid && !freeze;
    assign ovf_inc = capture && new_flag && !data_rd;

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            state    <= ST_IDLE;
            idx_q    <= 2'd0;
            rnw_q    <= 1'b0;
            be3_q    <= 1'b0;
            wctl_q   <= 2'd0;
            rd_snap  <= '0;
            sl_dbus  <= '0;
            xfer_ack <= 1'b0;
            data_reg <= 32'h0;
            new_flag <= 1'b0;
            ovf_cnt  <= 16'h0;
            freeze   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (hit) begin
                    state   <= ST_ACK;
                    idx_q   <= opb.OPB_ABus[28:29];
                    rnw_q   <= opb.OPB_RNW;
                    be3_q   <= opb.OPB_BE[3];
                    wctl_q  <= opb.OPB_DBus[30:31];
                    rd_snap <= opb.OPB_RNW ? rd_word : '0;
                end
                ST_ACK:  state <= ST_HOLD;
                ST_HOLD: if (!opb.OPB_select) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            xfer_ack <= acc;
            sl_dbus  <= acc ? rd_snap : '0;

            if (capture) begin
                data_reg <= user_data_in;
                new_flag <= 1'b1;
            end else if (data_rd) begin
                new_flag <= 1'b0;
            end

            if (ovf_clr)
                ovf_cnt <= 16'h0;
            else if (ovf_inc && (ovf_cnt != 16'hFFFF))
                ovf_cnt <= ovf_cnt + 16'h1;

            if (ctrl_wr)
                freeze <= wctl_q[1];
        end
    end

`ifdef OPB_SIM2PPC_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            ts_cnt <= 32'h0;
            tstamp <= 32'h0;
        end else begin
            ts_cnt <= ts_cnt + 32'h1;
            if (capture)
                tstamp <= ts_cnt;
        end
    end
`else
    assign tstamp = 32'h0;
`endif

    assign opb.Sl_DBus    = sl_dbus;
    assign opb.Sl_xferAck = xfer_ack;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;
    assign user_new       = new_flag;

    assign unused_ok = ^{opb.OPB_seqAddr, opb.OPB_BE[0:2], opb.OPB_DBus[0:29], FAMILY_V6};
endmodule

// File: tb/tb_opb_register_simulink2ppc_latched.sv
module tb_opb_register_simulink2ppc_latched;
    localparam logic [31:0] BASE = 32'h0110A100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] user_data_in = 32'h0;
    logic        user_valid = 1'b0;
    logic        user_new;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state, updated once per clock edge from the register rules.
    logic [31:0] m_data;
    logic        m_new;
    int          m_ovf;
    logic        m_freeze;
    logic [31:0] m_ts;
    logic [31:0] m_tc;

    opb_register_simulink2ppc_latched_if bus ();

    opb_register_simulink2ppc_latched dut (
        .OPB_Clk      (clk),
        .OPB_Rst_n    (rst_n),
        .opb          (bus),
        .user_data_in (user_data_in),
        .user_valid   (user_valid),
        .user_new     (user_new)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] idx);
        case (idx)
            2'd0:    return m_data;
            2'd1:    return {8'h00, m_ovf[15:0], 7'h00, m_new};
            2'd2:    return {30'h0, m_freeze, 1'b0};
`ifdef OPB_SIM2PPC_TIMESTAMP_EN
            default: return m_ts;
`else
            default: return 32'h0;
`endif
        endcase
    endfunction

    task automatic model_edge(input logic uv, input logic [31:0] ud, input logic rdclr,
                              input logic cwr, input logic [1:0] cval);
        logic cap;
        cap = uv && !m_freeze;
        if (cwr && cval[0])
            m_ovf = 0;
        else if (cap && m_new && !rdclr && m_ovf < 65535)
            m_ovf = m_ovf + 1;
        if (cap) begin
            m_data = ud;
            m_ts   = m_tc;
            m_new  = 1'b1;
        end else if (rdclr) begin
            m_new = 1'b0;
        end
        if (cwr)
            m_freeze = cval[1];
        m_tc = m_tc + 32'd1;
    endtask

    // One clock: present user inputs, advance the model at the edge, sample #1 later.
    task automatic cyc(input logic uv, input logic [31:0] ud, input logic rdclr,
                       input logic cwr, input logic [1:0] cval);
        user_valid   = uv;
        user_data_in = ud;
        @(posedge clk);
        if (!rst_n) begin
            m_data = 0; m_new = 0; m_ovf = 0; m_freeze = 0; m_ts = 0; m_tc = 0;
        end else begin
            model_edge(uv, ud, rdclr, cwr, cval);
        end
        #1;
        user_valid = 1'b0;
        chk("user_new", {31'h0, user_new}, {31'h0, m_new});
    endtask

    // One OPB transfer: select high for 'hold' edges, then one idle edge.
    task automatic opb(input logic rnw, input logic [1:0] idx, input logic [3:0] be,
                       input logic [31:0] wd, input int cap_at, input logic [31:0] cap_d,
                       input int hold, output logic [31:0] rd);
        logic [31:0] exp;
        logic [3:0]  hi;
        hi = 4'($urandom_range(0, 15));
        bus.OPB_select = 1'b1;
        bus.OPB_ABus   = BASE + {24'h0, hi, idx, 2'b00};
        bus.OPB_RNW    = rnw;
        bus.OPB_BE     = be;
        bus.OPB_DBus   = wd;
        exp = rnw ? model_read(idx) : 32'h0;
        rd  = 32'h0;
        for (int k = 0; k < hold; k++) begin
            cyc(cap_at == k, cap_d, (k == 1) && rnw && (idx == 2'd0),
                (k == 1) && !rnw && (idx == 2'd2) && be[0], wd[1:0]);
            if (k == 1) begin
                chk("ack", {31'h0, bus.Sl_xferAck}, 32'h1);
                chk("rdata", bus.Sl_DBus, exp);
                rd = bus.Sl_DBus;
            end else begin
                chk("no_ack", {31'h0, bus.Sl_xferAck}, 32'h0);
                chk("dbus_idle", bus.Sl_DBus, 32'h0);
            end
        end
        bus.OPB_select = 1'b0;
        bus.OPB_DBus   = $urandom;
        cyc(cap_at == hold, cap_d, 1'b0, 1'b0, 2'b00);
        chk("no_ack_tail", {31'h0, bus.Sl_xferAck}, 32'h0);
    endtask

    logic [31:0] rd, t1, t2;

    initial begin
        bus.OPB_ABus = 32'h0; bus.OPB_BE = 4'h0; bus.OPB_DBus = 32'h0;
        bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;

        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 2'b00);
        rst_n = 1'b1;
        chk("tied", {29'h0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            opb(1, 2'(i), 4'hF, 0, -1, 0, 3, rd);
            chk("reset_read", rd, 32'h0);
        end

        cyc(1, 32'hDEADBEEF, 0, 0, 2'b00);
        opb(1, 2'd1, 4'hF, 0, -1, 0, 3, rd); chk("status_new", rd, 32'h1);
        opb(1, 2'd0, 4'hF, 0, -1, 0, 3, rd); chk("data", rd, 32'hDEADBEEF);
        opb(1, 2'd1, 4'hF, 0, -1, 0, 3, rd); chk("status_clr", rd, 32'h0);

        for (int i = 0; i < 3; i++) cyc(1, 32'h100 + i, 0, 0, 2'b00);
        opb(1, 2'd1, 4'hF, 0, -1, 0, 3, rd); chk("status_ovf2", rd, 32'h201);
        opb(0, 2'd2, 4'b0001, 32'h1, -1, 0, 3, rd);
        opb(1, 2'd1, 4'hF, 0, -1, 0, 3, rd); chk("status_w1c", rd, 32'h1);

        opb(1, 2'd0, 4'hF, 0, 1, 32'hCAFEF00D, 3, rd); chk("race_old", rd, 32'h102);
        opb(1, 2'd1, 4'hF, 0, -1, 0, 3, rd); chk("race_status", rd, 32'h1);

        opb(1, 2'd0, 4'hF, 0, -1, 0, 3, rd); chk("data2", rd, 32'hCAFEF00D);
        opb(0, 2'd2, 4'b0001, 32'h2, -1, 0, 3, rd);
        opb(1, 2'd2, 4'hF, 0, -1, 0, 3, rd); chk("ctrl_freeze", rd, 32'h2);
        cyc(1, 32'h12345678, 0, 0, 2'b00);
        opb(1, 2'd0, 4'hF, 0, -1, 0, 3, rd); chk("frozen_data", rd, 32'hCAFEF00D);
        opb(1, 2'd1, 4'hF, 0, -1, 0, 3, rd); chk("frozen_new", rd, 32'h0);
        opb(0, 2'd2, 4'b0000, 32'h0, -1, 0, 3, rd);
        opb(1, 2'd2, 4'hF, 0, -1, 0, 3, rd); chk("ctrl_be0", rd, 32'h2);
        opb(0, 2'd2, 4'b0001, 32'h0, -1, 0, 3, rd);

`ifdef OPB_SIM2PPC_TIMESTAMP_EN
        cyc(1, 32'hA, 0, 0, 2'b00);
        opb(1, 2'd3, 4'hF, 0, -1, 0, 3, t1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 2'b00);
        cyc(1, 32'hB, 0, 0, 2'b00);
        opb(1, 2'd3, 4'hF, 0, -1, 0, 3, t2);
        chk("ts_delta", t2 - t1, 32'd10);
`else
        cyc(1, 32'hA, 0, 0, 2'b00);
        opb(1, 2'd3, 4'hF, 0, -1, 0, 3, t1); chk("ts_absent", t1, 32'h0);
`endif

        opb(1, 2'd1, 4'hF, 0, -1, 0, 5, rd);

        bus.OPB_select = 1'b1; bus.OPB_RNW = 1'b1;
        foreach (t1[i]) ;
        for (int j = 0; j < 2; j++) begin
            bus.OPB_ABus = (j == 0) ? 32'h0110A200 : 32'h0110A0FC;
            for (int i = 0; i < 4; i++) begin
                cyc(0, 0, 0, 0, 2'b00);
                chk("miss_no_ack", {31'h0, bus.Sl_xferAck}, 32'h0);
            end
        end
        bus.OPB_select = 1'b0;
        cyc(0, 0, 0, 0, 2'b00);

        for (int i = 0; i < 65540; i++) cyc(1, i, 0, 0, 2'b00);
        opb(1, 2'd1, 4'hF, 0, -1, 0, 3, rd); chk("ovf_sat", rd, 32'h00FFFF01);
        opb(0, 2'd2, 4'b0001, 32'h1, 1, 32'h5, 3, rd);
        opb(1, 2'd1, 4'hF, 0, -1, 0, 3, rd); chk("clr_beats_inc", rd, 32'h1);

        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                cyc(1'($urandom_range(0, 1)), $urandom, 0, 0, 2'b00);
            end else begin
                logic r;
                r = 1'($urandom_range(0, 1));
                opb(r, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    r ? $urandom : {30'h0, 2'($urandom_range(0, 3))},
                    $urandom_range(0, 5), $urandom, $urandom_range(3, 5), rd);
            end
        end

        bus.OPB_select = 1'b1; bus.OPB_RNW = 1'b1; bus.OPB_ABus = BASE + 32'h4;
        cyc(0, 0, 0, 0, 2'b00);
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 2'b00);
        chk("rst_abort", {31'h0, bus.Sl_xferAck}, 32'h0);
        rst_n = 1'b1;
        opb(1, 2'd1, 4'hF, 0, -1, 0, 3, rd); chk("post_rst", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/opb_register_simulink2ppc_latched.md
# opb_register_simulink2ppc_latched

OPB slave register that carries a 32-bit word from fabric logic up to the PowerPC. It is the read-back counterpart of the ppc2simulink register block. Fabric logic presents a word with a one-cycle valid strobe, and the block latches it with a "new data" flag. Software reads the word, a status word (new flag and overflow count) and, optionally, a capture timestamp over OPB. The block sits on the OPB alongside the other software registers and runs entirely in the OPB clock domain.

## Interface
- C_BASEADDR, 32'h0110A100, first byte address decoded
- C_HIGHADDR, 32'h0110A1FF, last byte address decoded
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width
- C_FAMILY, "virtex6", target family (informational)

Ports:
- OPB_Clk  in  1  sole clock; fabric side is synchronous to it
- OPB_Rst_n  in  1  reset; synchronous, active-low
- OPB_ABus  in  [0:31]  address
- OPB_BE  in  [0:3]  byte enables; BE[3] covers DBus[24:31]
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read, 0 = write
- OPB_select  in  1  transfer in progress
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data; zero except on the ack cycle
- Sl_xferAck  out  1  transfer acknowledge
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
- user_data_in  in  [31:0]  word to capture
- user_valid  in  1  capture strobe
- user_new  out  1  mirror of the new flag

## Operation
- Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Word index is OPB_ABus[28:29].
- Register map:
  - idx 0 DATA (RO): the captured word.
  - idx 1 STATUS (RO): bit0 = new flag; bits[23:8] = overflow count; all other bits 0.
  - idx 2 CTRL (R/W): bit0 is write-1-to-clear of the overflow count and reads 0; bit1 = freeze, reads back.
  - idx 3 TSTAMP (RO): see Configuration.
- Writes to idx 0/1/3 are acked and ignored. A CTRL write takes effect only when BE[3]=1.
- Capture: when user_valid=1 and freeze=0, DATA <= user_data_in and new <= 1.
  - If new was already 1 and is not being cleared in the same cycle, the overflow count increments.
  - The overflow count saturates at 0xFFFF.
- A read ack of DATA clears new. If a capture occurs in the same cycle: capture wins, new stays 1, no overflow increment.
- A CTRL clear and an overflow increment in the same cycle: the clear wins, count = 0.
- Slave FSM:
  - IDLE -> ACK on hit.
  - ACK (one cycle) -> HOLD.
  - HOLD -> IDLE when OPB_select=0. This guarantees a single ack per select.
- Sl_DBus is driven only in ACK. It carries the read snapshot taken in the IDLE->ACK cycle, and is 0 when OPB_RNW=0.
- Reset: FSM=IDLE. DATA, new, overflow, freeze, TSTAMP and the timestamp counter are all 0. Sl_xferAck=0, Sl_DBus=0, user_new=0.
- Reset asserted mid-transfer aborts it with no ack. After reset, a still-high OPB_select is treated as a new hit.

## Timing
- Hit sampled at edge N; Sl_xferAck=1 for exactly the cycle after edge N+1 (one wait state).
- Read data reflects register state at edge N. A capture at edge N is not visible; a capture at N-1 is.
- CTRL write takes effect at the ack edge. DATA-read clear of new takes effect at the ack edge.
- user_new follows new with zero added latency (direct register output).
- Earliest re-hit: two cycles after OPB_select falls in HOLD.

## Configuration
- OPB_SIM2PPC_TIMESTAMP_EN defined:
  - A free-running 32-bit cycle counter (wraps 0xFFFFFFFF -> 0) runs on OPB_Clk.
  - Its value is latched into TSTAMP on every accepted capture.
- Not defined: the counter is absent and TSTAMP reads 0.

## Test plan
- Reset, then read idx 0/1/2/3 -> all 0x00000000; one ack per read, on the second cycle after select.
- user_valid with 0xDEADBEEF, then read DATA -> 0xDEADBEEF. STATUS before the read = 0x00000001; after = 0x00000000.
- Three captures with no read, then read STATUS -> 0x00000201 (count 2, new 1). Write CTRL=0x1 with BE=4'b0001 -> STATUS 0x00000001.
- user_valid coincident with the DATA read ack -> returned word is the old one, new stays 1, count unchanged.
- Write CTRL=0x2 (freeze), then pulse user_valid 0x12345678 -> DATA unchanged, new stays 0. Write CTRL with BE=4'b0000 -> no effect.
- With OPB_SIM2PPC_TIMESTAMP_EN, capture 10 cycles apart -> TSTAMP difference = 10. Without the macro -> TSTAMP = 0. Also: OPB_select held 5 cycles -> exactly one Sl_xferAck.
